wb_arbiter: RTL and testbench

Write-back port arbiter between the execute stage and the load unit. Both producers deliver results with the same valid/stall pipeline handshake the execute stage already uses. The register file has a single write port, so this block buffers one result per producer and grants the port round-robin. Registered write-port signals go straight to the register file.

---
 rtl/wb_arbiter.sv | 142 ++++++++++++++
 tb/tb_wb_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Purpose  : Write-back port arbiter between the execute stage and the load
//            unit. Each producer owns a one-entry buffer slot; the single
//            register-file write port is granted round-robin among slots
//            holding an entry that needs write-back.
// Ports    : clk, rst (async, active-low)
//            ex_v_i / ex_stall_o / ex_rd_num_i / ex_wb_i / ex_rd_data_i
//                   execute-stage result handshake and payload
//            ld_v_i / ld_stall_o / ld_rd_num_i / ld_wb_i / ld_rd_data_i
//                   load-unit result handshake and payload
//            rf_we_o / rf_num_o / rf_data_o  registered write port
//            busy_o  either slot holds an entry
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
    parameter int WORD = 32,
    parameter int W_RD = 5
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            ex_v_i,
    output logic            ex_stall_o,
    input  logic [W_RD-1:0] ex_rd_num_i,
    input  logic            ex_wb_i,
    input  logic [WORD-1:0] ex_rd_data_i,

    input  logic            ld_v_i,
    output logic            ld_stall_o,
    input  logic [W_RD-1:0] ld_rd_num_i,
    input  logic            ld_wb_i,
    input  logic [WORD-1:0] ld_rd_data_i,

    output logic            rf_we_o,
    output logic [W_RD-1:0] rf_num_o,
    output logic [WORD-1:0] rf_data_o,
    output logic            busy_o
);

    // Encoding of the most recent grant winner.
    localparam logic c_GNT_EX = 1'b0;
    localparam logic c_GNT_LD = 1'b1;

    logic            r_ex_v;
    logic            r_ex_wb;
    logic [W_RD-1:0] r_ex_num;
    logic [WORD-1:0] r_ex_data;

    logic            r_ld_v;
    logic            r_ld_wb;
    logic [W_RD-1:0] r_ld_num;
    logic [WORD-1:0] r_ld_data;

    logic            r_last_grant;

    logic w_ex_elig;
    logic w_ld_elig;
    logic w_gnt_ex;
    logic w_gnt_ld;
    logic w_ex_drain;
    logic w_ld_drain;
    logic w_ex_acc;
    logic w_ld_acc;

    // Only entries that actually write compete for the port.
    assign w_ex_elig = r_ex_v & r_ex_wb;
    assign w_ld_elig = r_ld_v & r_ld_wb;

    // On a contest the requester that did not win last time gets the port.
    assign w_gnt_ex = w_ex_elig & (~w_ld_elig | (r_last_grant == c_GNT_LD));
    assign w_gnt_ld = w_ld_elig & (~w_ex_elig | (r_last_grant == c_GNT_EX));

    // A slot empties when it is granted, or unconditionally when its entry
    // carries no write-back.
    assign w_ex_drain = r_ex_v & (~r_ex_wb | w_gnt_ex);
    assign w_ld_drain = r_ld_v & (~r_ld_wb | w_gnt_ld);

    // A draining slot refills at the same edge, giving 1/cycle throughput.
    assign ex_stall_o = r_ex_v & ~w_ex_drain;
    assign ld_stall_o = r_ld_v & ~w_ld_drain;

    assign w_ex_acc = ex_v_i & ~ex_stall_o;
    assign w_ld_acc = ld_v_i & ~ld_stall_o;

    assign busy_o = r_ex_v | r_ld_v;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ex_v       <= 1'b0;
            r_ex_wb      <= 1'b0;
            r_ex_num     <= '0;
            r_ex_data    <= '0;
            r_ld_v       <= 1'b0;
            r_ld_wb      <= 1'b0;
            r_ld_num     <= '0;
            r_ld_data    <= '0;
            r_last_grant <= c_GNT_LD;
            rf_we_o      <= 1'b0;
            rf_num_o     <= '0;
            rf_data_o    <= '0;
        end else begin
            // Execute slot
            if (w_ex_acc) begin
                r_ex_v    <= 1'b1;
                r_ex_wb   <= ex_wb_i;
                r_ex_num  <= ex_rd_num_i;
                r_ex_data <= ex_rd_data_i;
            end else if (w_ex_drain) begin
                r_ex_v    <= 1'b0;
            end

            // Load slot
            if (w_ld_acc) begin
                r_ld_v    <= 1'b1;
                r_ld_wb   <= ld_wb_i;
                r_ld_num  <= ld_rd_num_i;
                r_ld_data <= ld_rd_data_i;
            end else if (w_ld_drain) begin
                r_ld_v    <= 1'b0;
            end

            // Write port; address and data hold when idle.
            if (w_gnt_ex) begin
                rf_we_o      <= 1'b1;
                rf_num_o     <= r_ex_num;
                rf_data_o    <= r_ex_data;
                r_last_grant <= c_GNT_EX;
            end else if (w_gnt_ld) begin
                rf_we_o      <= 1'b1;
                rf_num_o     <= r_ld_num;
                rf_data_o    <= r_ld_data;
                r_last_grant <= c_GNT_LD;
            end else begin
                rf_we_o      <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter
// Purpose  : Self-checking bench for wb_arbiter. A stream driver feeds both
//            producers; every accepted write-back entry is queued with its
//            acceptance edge, and a monitor pops and compares each cycle
//            using the round-robin rules for the write port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

    localparam int WORD = 32;
    localparam int W_RD = 5;

    typedef struct {
        logic [W_RD-1:0] num;
        logic            wb;
        logic [WORD-1:0] data;
    } item_t;

    typedef struct {
        logic [W_RD-1:0] num;
        logic [WORD-1:0] data;
        int              edge_n;
    } exp_t;

    logic            clk;
    logic            rst;
    logic            ex_v_i, ex_stall_o, ex_wb_i;
    logic [W_RD-1:0] ex_rd_num_i;
    logic [WORD-1:0] ex_rd_data_i;
    logic            ld_v_i, ld_stall_o, ld_wb_i;
    logic [W_RD-1:0] ld_rd_num_i;
    logic [WORD-1:0] ld_rd_data_i;
    logic            rf_we_o;
    logic [W_RD-1:0] rf_num_o;
    logic [WORD-1:0] rf_data_o;
    logic            busy_o;

    wb_arbiter #(.WORD(WORD), .W_RD(W_RD)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_v_i       (ex_v_i),
        .ex_stall_o   (ex_stall_o),
        .ex_rd_num_i  (ex_rd_num_i),
        .ex_wb_i      (ex_wb_i),
        .ex_rd_data_i (ex_rd_data_i),
        .ld_v_i       (ld_v_i),
        .ld_stall_o   (ld_stall_o),
        .ld_rd_num_i  (ld_rd_num_i),
        .ld_wb_i      (ld_wb_i),
        .ld_rd_data_i (ld_rd_data_i),
        .rf_we_o      (rf_we_o),
        .rf_num_o     (rf_num_o),
        .rf_data_o    (rf_data_o),
        .busy_o       (busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int edges = 0;
    always @(posedge clk) edges <= edges + 1;

    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 1'b0;
    bit    last_ld;
    item_t ex_src[$];
    item_t ld_src[$];
    exp_t  ex_exp[$];
    exp_t  ld_exp[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: an entry accepted at edge N may be granted in the cycle
    // after edge N and appears on the port after edge N+1. When both heads
    // are eligible, the requester not written last wins.
    task automatic monitor();
        exp_t e;
        bit   ex_c, ld_c, take_ex;
        forever begin
            @(negedge clk);
            if (!rst) begin
                last_ld = 1'b1;
            end else if (mon_en) begin
                ex_c = (ex_exp.size() > 0) && (ex_exp[0].edge_n <= edges - 1);
                ld_c = (ld_exp.size() > 0) && (ld_exp[0].edge_n <= edges - 1);
                if (ex_c || ld_c) begin
                    take_ex = ex_c && (!ld_c || last_ld);
                    if (take_ex) e = ex_exp.pop_front();
                    else         e = ld_exp.pop_front();
                    last_ld = !take_ex;
                    chk(take_ex ? "write_ex" : "write_ld",
                        {26'd0, rf_we_o, rf_num_o, rf_data_o},
                        {26'd0, 1'b1, e.num, e.data});
                end else begin
                    chk("idle_we", {63'd0, rf_we_o}, 64'd0);
                end
            end
        end
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        ex_v_i  = 1'b0;
        ld_v_i  = 1'b0;
        ex_exp.delete();
        ld_exp.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Drives both source queues, holding payload while stalled; gap is the
    // percentage chance of idling when a new item is available.
    task automatic run(input int gap, input int maxc,
                       output int max_run, output int ex_st, output int ld_st);
        bit    ex_hold = 1'b0;
        bit    ld_hold = 1'b0;
        item_t ex_cur, ld_cur;
        int    c   = 0;
        int    cur = 0;
        max_run = 0;
        ex_st   = 0;
        ld_st   = 0;
        while ((ex_src.size() > 0 || ld_src.size() > 0 || ex_hold || ld_hold ||
                ex_exp.size() > 0 || ld_exp.size() > 0) && c < maxc) begin
            @(negedge clk);
            c++;
            if (!ex_hold && ex_src.size() > 0 && $urandom_range(99) >= gap) begin
                ex_cur  = ex_src.pop_front();
                ex_hold = 1'b1;
            end
            if (!ld_hold && ld_src.size() > 0 && $urandom_range(99) >= gap) begin
                ld_cur  = ld_src.pop_front();
                ld_hold = 1'b1;
            end
            ex_v_i       = ex_hold;
            ex_rd_num_i  = ex_hold ? ex_cur.num  : W_RD'($urandom);
            ex_wb_i      = ex_hold ? ex_cur.wb   : 1'($urandom);
            ex_rd_data_i = ex_hold ? ex_cur.data : $urandom;
            ld_v_i       = ld_hold;
            ld_rd_num_i  = ld_hold ? ld_cur.num  : W_RD'($urandom);
            ld_wb_i      = ld_hold ? ld_cur.wb   : 1'($urandom);
            ld_rd_data_i = ld_hold ? ld_cur.data : $urandom;
            #1;
            if (rf_we_o) cur++;
            else         cur = 0;
            if (cur > max_run) max_run = cur;
            if (ex_stall_o) ex_st++;
            if (ld_stall_o) ld_st++;
            if (ex_hold && !ex_stall_o) begin
                if (ex_cur.wb) ex_exp.push_back('{num: ex_cur.num, data: ex_cur.data, edge_n: edges + 1});
                ex_hold = 1'b0;
            end
            if (ld_hold && !ld_stall_o) begin
                if (ld_cur.wb) ld_exp.push_back('{num: ld_cur.num, data: ld_cur.data, edge_n: edges + 1});
                ld_hold = 1'b0;
            end
        end
        if (c >= maxc) begin
            checks++;
            errors++;
            $display("FAIL run_timeout actual=%0d cycles required=<%0d", c, maxc);
            ex_src.delete();
            ld_src.delete();
        end
        @(negedge clk);
        ex_v_i = 1'b0;
        ld_v_i = 1'b0;
    endtask

    int mr, es, ls, wcnt;

    initial begin
        rst = 1'b0;
        ex_v_i = 1'b0; ex_rd_num_i = '0; ex_wb_i = 1'b0; ex_rd_data_i = '0;
        ld_v_i = 1'b0; ld_rd_num_i = '0; ld_wb_i = 1'b0; ld_rd_data_i = '0;
        last_ld = 1'b1;
        fork
            monitor();
        join_none

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_we",    {63'd0, rf_we_o},    64'd0);
        chk("rst_num",   {59'd0, rf_num_o},   64'd0);
        chk("rst_data",  {32'd0, rf_data_o},  64'd0);
        chk("rst_exst",  {63'd0, ex_stall_o}, 64'd0);
        chk("rst_ldst",  {63'd0, ld_stall_o}, 64'd0);
        chk("rst_busy",  {63'd0, busy_o},     64'd0);
        rst    = 1'b1;
        mon_en = 1'b1;

        // Single EX write; port address/data hold once idle
        ex_src.push_back('{num: 5'd3, wb: 1'b1, data: 32'h12345678});
        run(0, 50, mr, es, ls);
        chk("single_hold_we",   {63'd0, rf_we_o},   64'd0);
        chk("single_hold_num",  {59'd0, rf_num_o},  64'd3);
        chk("single_hold_data", {32'd0, rf_data_o}, 64'h12345678);

        // Simultaneous arrival after reset: EX first, LD stalls one cycle
        do_reset();
        ex_src.push_back('{num: 5'd1, wb: 1'b1, data: 32'hA});
        ld_src.push_back('{num: 5'd2, wb: 1'b1, data: 32'hB});
        run(0, 50, mr, es, ls);
        chk("simul_ld_stall_cycles", 64'(ls), 64'd1);
        chk("simul_ex_stall_cycles", 64'(es), 64'd0);

        // Sustained contention: 16 back-to-back writes
        for (int i = 0; i < 8; i++) begin
            ex_src.push_back('{num: W_RD'(i + 1),  wb: 1'b1, data: 32'hE000_0000 + i});
            ld_src.push_back('{num: W_RD'(i + 16), wb: 1'b1, data: 32'h1D00_0000 + i});
        end
        run(0, 100, mr, es, ls);
        chk("sustain_run", 64'(mr), 64'd16);

        // EX without write-back never stalls; LD writes at full rate
        for (int i = 0; i < 8; i++) begin
            ex_src.push_back('{num: W_RD'(i), wb: 1'b0, data: $urandom});
            ld_src.push_back('{num: W_RD'(i + 8), wb: 1'b1, data: $urandom});
        end
        run(0, 100, mr, es, ls);
        chk("nowb_ex_stall", 64'(es), 64'd0);
        chk("nowb_ld_run",   64'(mr), 64'd8);

        // Back-to-back single requester
        for (int i = 0; i < 5; i++)
            ld_src.push_back('{num: W_RD'(i + 20), wb: 1'b1, data: $urandom});
        run(0, 50, mr, es, ls);
        chk("b2b_ld_stall", 64'(ls), 64'd0);
        chk("b2b_run",      64'(mr), 64'd5);

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            ex_src.push_back('{num: W_RD'($urandom), wb: ($urandom_range(3) != 0), data: $urandom});
            ld_src.push_back('{num: W_RD'($urandom), wb: ($urandom_range(3) != 0), data: $urandom});
        end
        run(30, 2000, mr, es, ls);

        // Reset mid-stream with both slots full and a write on the port
        @(negedge clk);
        mon_en       = 1'b0;
        ex_v_i       = 1'b1; ex_rd_num_i = 5'd7; ex_wb_i = 1'b1; ex_rd_data_i = 32'h77;
        ld_v_i       = 1'b1; ld_rd_num_i = 5'd8; ld_wb_i = 1'b1; ld_rd_data_i = 32'h88;
        @(negedge clk);
        ex_rd_num_i  = 5'd9; ex_rd_data_i = 32'h99;
        @(posedge clk);
        #2;
        chk("mid_pre_we",   {63'd0, rf_we_o}, 64'd1);
        chk("mid_pre_busy", {63'd0, busy_o},  64'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_we",   {63'd0, rf_we_o},    64'd0);
        chk("mid_rst_exst", {63'd0, ex_stall_o}, 64'd0);
        chk("mid_rst_ldst", {63'd0, ld_stall_o}, 64'd0);
        chk("mid_rst_busy", {63'd0, busy_o},     64'd0);
        chk("mid_rst_num",  {59'd0, rf_num_o},   64'd0);
        ex_v_i = 1'b0;
        ld_v_i = 1'b0;
        ex_exp.delete();
        ld_exp.delete();
        repeat (2) @(negedge clk);
        rst    = 1'b1;
        mon_en = 1'b1;
        wcnt   = 0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (rf_we_o) wcnt++;
        end
        chk("mid_no_stale_write", 64'(wcnt), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
